// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage in front of the decoder. Owns the program counter,
//   issues word fetches over a request/grant/response memory handshake with
//   variable latency, buffers returned words with their PCs in a small FIFO and
//   presents them to the decoder over valid/ready. A redirect loads a new PC,
//   empties the FIFO and marks every in-flight response as stale.
//
//   Optional feature macro: FETCH_PERF_CNT_EN adds the stall_cycles counter.
//
// Parameters
//   RESET_PC    first PC fetched after reset (word aligned)
//   FIFO_DEPTH  buffer entries (power of two, >= 2); also the outstanding cap
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   imem_req/imem_addr    fetch request and word address (address = fetch PC)
//   imem_gnt              request accepted this cycle
//   imem_rvalid/rdata     in-order response
//   redirect/redirect_pc  control-flow change, low two PC bits ignored
//   instr_valid/ready     decoder handshake
//   instr/instr_pc        head instruction and its address
//   stall_cycles          cycles without a valid instruction (macro only)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough for occupancy + outstanding, both bounded by FIFO_DEPTH.
    localparam int CW = $clog2(FIFO_DEPTH) + 2;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_word [FIFO_DEPTH];
    logic [31:0]   r_pc   [FIFO_DEPTH];

    logic          w_pop;
    logic          w_grant;
    logic          w_drop;
    logic          w_push;
    logic [31:0]   w_target;
    logic [CW-1:0] w_used;
    logic          w_unused;

    assign w_target  = {redirect_pc[31:2], 2'b00};
    assign w_unused  = ^redirect_pc[1:0];
    assign w_pop     = instr_valid && instr_ready;
    assign w_grant   = imem_req && imem_gnt;
    assign w_drop    = (r_drop_cnt != {CW{1'b0}});
    // A response arriving in the redirect cycle is stale by definition.
    assign w_push    = imem_rvalid && !redirect && !w_drop;
    // Credits: buffered + in flight, minus the entry leaving this cycle.
    assign w_used    = r_count + r_outstanding - CW'(w_pop);

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != {CW{1'b0}});
    assign instr       = r_word[r_rd_ptr];
    assign instr_pc    = r_pc[r_rd_ptr];

    // Request generation from the credit rule; suppressed in reset and redirect cycles.
    always_comb begin
        imem_req = 1'b0;
        if (reset) begin
            imem_req = 1'b0;
        end else if (redirect) begin
            imem_req = 1'b0;
        end else begin
            imem_req = (w_used < CW'(FIFO_DEPTH));
        end
    end

    // Program counters for the next request and the next expected response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
        end
    end

    // In-flight request count and the number of stale responses still to discard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= {CW{1'b0}};
            r_drop_cnt    <= {CW{1'b0}};
        end else begin
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(imem_rvalid);
            if (redirect) begin
                // Everything in flight becomes stale, except a response landing now.
                r_drop_cnt <= r_drop_cnt + r_outstanding - CW'(imem_rvalid);
            end else if (imem_rvalid && w_drop) begin
                r_drop_cnt <= r_drop_cnt - {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer after any pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (redirect) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage of {word, pc}; cleared on reset so the decoder sees zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_word[i] <= 32'h0000_0000;
                r_pc[i]   <= 32'h0000_0000;
            end
        end else if (w_push) begin
            r_word[r_wr_ptr] <= imem_rdata;
            r_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of cycles with no instruction offered; survives redirects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 32'h0000_0000;
        end else if (!instr_valid && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A fixed-latency memory model answers
//   each granted address with (address ^ data_xor). Expected {pc, word} pairs
//   are queued by each scenario and compared whenever the decoder pops.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int          TB_DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    fetch_unit #(.RESET_PC(TB_RESET_PC), .FIFO_DEPTH(TB_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] data_xor = 32'h0;

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];
    pend_t mm_tmp;
    int    cyc = 0;
    int    lat = 1;
    int    grant_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            grant_cnt = 0;
        end else begin
            if (imem_rvalid) mm_tmp = pend.pop_front();
            if (imem_req && imem_gnt) begin
                pend.push_back('{imem_addr, cyc + lat});
                grant_cnt++;
            end
        end
        cyc++;
        #1;
        if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ data_xor;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h, required no instruction", instr_pc, instr);
            end else begin
                mon_e = sb.pop_front();
                if (instr_pc !== mon_e.pc || instr !== mon_e.word) begin
                    errors++;
                    $display("FAIL pop_order: got pc=%h instr=%h, required pc=%h instr=%h",
                             instr_pc, instr, mon_e.pc, mon_e.word);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] pc, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = pc + 32'(4 * i);
            sb.push_back('{p, p ^ data_xor});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        sb.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expected instructions never arrived, required 0", sb.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        instr_ready = 1'b0;
        imem_gnt    = 1'b0;
        reset       = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== TB_RESET_PC) begin
            errors++;
            $display("FAIL reset_req: got req=%b addr=%h, required req=0 addr=%h", imem_req, imem_addr, TB_RESET_PC);
        end
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got valid=%b instr=%h pc=%h, required 0/0/0", instr_valid, instr, instr_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (stall_cycles !== 32'h0) begin
            errors++;
            $display("FAIL reset_stall: got %0d, required 0", stall_cycles);
        end
`endif
        step();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== TB_RESET_PC) begin
                errors++;
                $display("FAIL first_req c%0d: got req=%b addr=%h, required req=1 addr=%h", c, imem_req, imem_addr, TB_RESET_PC);
            end
            step();
        end
        imem_gnt = 1'b1;
    endtask

    task automatic test_stream();
        logic exp_v;
        data_xor    = 32'h0;
        lat         = 1;
        instr_ready = 1'b1;
        do_reset();
        push_exp(32'h0, 4);
        for (int c = 0; c < 6; c++) begin
            exp_v = (c >= 2);
            @(negedge clk);
            checks++;
            if (instr_valid !== exp_v) begin
                errors++;
                $display("FAIL stream_valid c%0d: got %b, required %b", c, instr_valid, exp_v);
            end
            step();
        end
        instr_ready = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d left, required 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        data_xor    = 32'h1357_9BDF;
        lat         = 1;
        instr_ready = 1'b0;
        do_reset();
        repeat (6) step();
        @(negedge clk);
        checks++;
        if (grant_cnt != TB_DEPTH) begin
            errors++;
            $display("FAIL bp_grants: got %0d grants, required %0d", grant_cnt, TB_DEPTH);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_head: got valid=%b pc=%h, required 1/00000000", instr_valid, instr_pc);
        end
        step();
        push_exp(32'h0, 5);
        instr_ready = 1'b1;
        wait_drain(30);
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_stale();
        data_xor    = 32'h0F0F_0F0F;
        lat         = 3;
        instr_ready = 1'b1;
        do_reset();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (grant_cnt != 2 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stale_setup: got grants=%0d req=%b, required 2/0", grant_cnt, imem_req);
        end
        #1;
        push_exp(32'h0000_0100, 3);
        step();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_flush: got valid=%b, required 0", instr_valid);
        end
        wait_drain(40);
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_pop();
        data_xor    = 32'h2468_ACE0;
        lat         = 1;
        instr_ready = 1'b1;
        do_reset();
        push_exp(32'h0, 1);
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rp_cycle: got valid=%b pc=%h req=%b, required 1/00000000/0", instr_valid, instr_pc, imem_req);
        end
        #1;
        push_exp(32'h0000_0200, 3);
        step();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL rp_after: got valid=%b req=%b addr=%h, required 0/1/00000200", instr_valid, imem_req, imem_addr);
        end
        wait_drain(30);
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        data_xor    = 32'hCAFE_0001;
        lat         = 1;
        instr_ready = 1'b1;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        #1;
        push_exp(32'hFFFF_FFF8, 4);
        step();
        redirect = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_addr: got req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
        end
        wait_drain(30);
        instr_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        held;
        logic [31:0] held_addr;
        data_xor    = 32'h7777_1111;
        lat         = 2;
        instr_ready = 1'b0;
        do_reset();
        push_exp(32'h0, 100);
        held = 1'b0;
        held_addr = 32'h0;
        for (int c = 0; c < 80; c++) begin
            instr_ready = 1'($urandom_range(0, 1));
            imem_gnt    = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (held) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== held_addr) begin
                    errors++;
                    $display("FAIL addr_hold c%0d: got req=%b addr=%h, required 1/%h", c, imem_req, imem_addr, held_addr);
                end
            end
            held      = imem_req && !imem_gnt;
            held_addr = imem_addr;
            step();
        end
        instr_ready = 1'b0;
        imem_gnt    = 1'b1;
        checks++;
        if (sb.size() >= 100) begin
            errors++;
            $display("FAIL b2b_progress: got %0d pops, required at least 1", 100 - sb.size());
        end
        sb.delete();
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        int exp_stall;
        data_xor    = 32'h0;
        lat         = 2;
        instr_ready = 1'b1;
        do_reset();
        push_exp(32'h0, 16);
        exp_stall = 0;
        for (int c = 0; c < 30; c++) begin
            redirect    = (c == 12);
            redirect_pc = 32'h0000_0400;
            @(negedge clk);
            checks++;
            if (stall_cycles !== 32'(exp_stall)) begin
                errors++;
                $display("FAIL stall_cnt c%0d: got %0d, required %0d", c, stall_cycles, exp_stall);
            end
            if (!instr_valid) exp_stall++;
            if (c == 12) begin
                #1;
                sb.delete();
                push_exp(32'h0000_0400, 16);
            end
            step();
        end
        redirect    = 1'b0;
        instr_ready = 1'b0;
        sb.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_pop();
        test_wrap();
        test_back_to_back();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        reset = 1'b1;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
